serial_alu_seq: RTL and testbench

- Bit-serial sequencer for the 4-function calculator (XOR, NAND, ADD, SUB).
- Time-multiplexes one 1-bit full-adder/subtractor slice over WIDTH cycles to process multi-bit operands at minimal area.
- Sits between a requester (valid/ready in) and a consumer (valid/ready out).
- Op encoding matches the calculator select pair {c,d}: 00 XOR, 01 NAND, 10 ADD, 11 SUB.

---
 rtl/serial_alu_pkg.sv | 5 +
 rtl/alu_bit_slice.sv | 19 +
 rtl/serial_alu_seq.sv | 90 +++++++++
 tb/tb_serial_alu_seq.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: op and state types shared by the bit-serial ALU sequencer
package serial_alu_pkg;
    typedef enum logic [1:0] {OP_XOR = 2'b00, OP_NAND = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11} alu_op_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: one-bit XOR/NAND/ADD/SUB slice; cout passes cin through for logic ops
module alu_bit_slice
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       r,
    output logic       cout
);
    logic x;
    assign x = a ^ b;
    always_comb begin
        r    = (op == OP_NAND) ? ~(a & b) : (op[1] ? x ^ cin : x);
        cout = (op == OP_ADD) ? ((a & b) | (cin & x)) :
               (op == OP_SUB) ? ((~a & b) | (cin & ~x)) : cin;
    end
endmodule

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial XOR/NAND/ADD/SUB sequencer with valid/ready handshakes
// SERIAL_ALU_SEQ_ZERO_FLAG_EN adds a zero output built up bit by bit during RUN
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
`ifdef SERIAL_ALU_SEQ_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             flag
);
    localparam int IW = $clog2(WIDTH);
    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       op_q;
    logic             carry, r, cout, last, accept;
    logic [IW-1:0]    idx;

    alu_bit_slice u_slice (
        .a   (a_q[idx]),
        .b   (b_q[idx]),
        .cin (carry),
        .op  (op_q),
        .r   (r),
        .cout(cout)
    );

    assign accept = in_valid && in_ready;
    assign last   = idx == IW'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        state_nx  = (state == IDLE) ? (in_valid ? RUN : IDLE) :
                    (state == RUN)  ? (last ? DONE : RUN) :
                    (state == DONE) ? (out_ready ? IDLE : DONE) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            flag   <= 1'b0;
        end else if (accept) begin
            a_q    <= a;
            b_q    <= b;
            op_q   <= op;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            flag   <= 1'b0;
        end else if (state == RUN) begin
            result[idx] <= r;
            idx         <= idx + 1'b1;
            if (op_q[1]) carry <= cout;
            if (last) flag <= op_q[1] & cout;
        end
    end

`ifdef SERIAL_ALU_SEQ_ZERO_FLAG_EN
    logic zacc;
    // Running AND of ~r avoids a WIDTH-wide compare on the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                zacc <= 1'b0;
        else if (accept)           zacc <= 1'b1;
        else if (state == RUN)     zacc <= zacc & ~r;
    end
    assign zero = out_valid & zacc;
`endif
endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: randomized and directed checks of serial_alu_seq against an arithmetic model
module tb_serial_alu_seq;
    localparam int W = 8;
    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, flag;
    logic [W-1:0] result;
`ifdef SERIAL_ALU_SEQ_ZERO_FLAG_EN
    logic         zero;
`endif
    int n_tests = 0, n_fail = 0;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
`ifdef SERIAL_ALU_SEQ_ZERO_FLAG_EN
        .zero     (zero),
`endif
        .flag     (flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {flag, result} from plain integer arithmetic
    function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        d = x - y;
        case (o)
            2'b00:   model = {1'b0, x ^ y};
            2'b01:   model = {1'b0, ~(x & y)};
            2'b10:   model = {1'b0, x} + {1'b0, y};
            default: model = {x < y, d};
        endcase
    endfunction

    task automatic start(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int n = 0;
        while (!in_ready && n < 4 * W) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_before_accept", in_ready, 1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 2'($urandom); a = W'($urandom); b = W'($urandom);
        check("in_ready_drop", in_ready, 0);
    endtask

    task automatic finish(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
        logic [W:0] e;
        int n = 0;
        e = model(o, x, y);
        while (!out_valid && n < 4 * W) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, W);
        check("result", result, e[W-1:0]);
        check("flag", flag, e[W]);
`ifdef SERIAL_ALU_SEQ_ZERO_FLAG_EN
        check("zero", zero, e[W-1:0] == '0);
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_result", result, e[W-1:0]);
            check("hold_flag", flag, e[W]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        logic [W:0]   e;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flag", flag, 0);
`ifdef SERIAL_ALU_SEQ_ZERO_FLAG_EN
        check("rst_zero", zero, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        start(2'b10, 8'h5A, 8'h3C); finish(2'b10, 8'h5A, 8'h3C, 0);
        start(2'b10, 8'hFF, 8'h01); finish(2'b10, 8'hFF, 8'h01, 0);
        start(2'b11, 8'h10, 8'h20); finish(2'b11, 8'h10, 8'h20, 0);
        start(2'b11, 8'h20, 8'h10); finish(2'b11, 8'h20, 8'h10, 0);
        start(2'b00, 8'hF0, 8'hAA); finish(2'b00, 8'hF0, 8'hAA, 0);
        start(2'b01, 8'hF0, 8'hAA); finish(2'b01, 8'hF0, 8'hAA, 0);
        start(2'b11, 8'h00, 8'h00); finish(2'b11, 8'h00, 8'h00, 1);

        // Backpressure with new requests pulsing at the input
        start(2'b11, 8'h05, 8'h07);
        e = model(2'b11, 8'h05, 8'h07);
        for (int n = 0; n < 4 * W && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_result", result, e[W-1:0]);
            check("bp_flag", flag, e[W]);
        end
        op = 2'b10; a = 8'h33; b = 8'h44; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_valid", out_valid, 0);
        check("bp_no_accept_on_handshake", in_ready, 1);
        start(2'b10, 8'h33, 8'h44); finish(2'b10, 8'h33, 8'h44, 0);

        // Asynchronous reset in the middle of RUN
        start(2'b10, 8'hFF, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("partial_result", result, 8'h07);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_result", result, 0);
        check("async_rst_flag", flag, 0);
        check("async_rst_valid", out_valid, 0);
        check("async_rst_ready", in_ready, 1);
        @(posedge clk); #1;
        check("rst_held_valid", out_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", in_ready, 1);
        start(2'b10, 8'h01, 8'h01); finish(2'b10, 8'h01, 8'h01, 0);

        for (int k = 0; k < 40; k++) begin
            ro = 2'($urandom); ra = W'($urandom); rb = W'($urandom);
            if (k % 8 == 0) rb = ra;
            start(ro, ra, rb);
            finish(ro, ra, rb, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
